// File: rtl/count_ctrl_if.sv
// Host-side handshake and count bus for count_ctrl.
// master = host/control block, slave = count_ctrl.
interface count_ctrl_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
);
  logic                  start;
  logic                  stop;
  logic                  ack;
  logic [WIDTH-1:0]      term;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic                  done;
  logic                  wrap;

  modport master (
    output start, stop, ack, term, prescale,
    input  q, busy, done, wrap
  );

  modport slave (
    input  start, stop, ack, term, prescale,
    output q, busy, done, wrap
  );
endinterface

// File: rtl/count_ctrl.sv
// Prescaled start/stop/done/ack count engine for the 4-bit counter datapath.
// Build option COUNT_CTRL_RELOAD_EN: auto-reload at the terminal tick instead of one-shot DONE.
module count_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input logic         clk,
  input logic         rst,
  count_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      q_r, q_nxt;
  logic [WIDTH-1:0]      term_r, term_nxt;
  logic [PRESCALE_W-1:0] psc_r, psc_nxt;
  logic [PRESCALE_W-1:0] pre_r, pre_nxt;
  logic                  busy_r, busy_nxt;
  logic                  done_r, done_nxt;
  logic                  wrap_r, wrap_nxt;

  logic accept_c;
  logic tick_c;
  logic term_hit_c;

  assign accept_c   = (state == S_IDLE) && bus.start && !bus.stop;
  assign tick_c     = (state == S_RUN) && (psc_r == pre_r);
  // Compare precedes increment, so q saturates at term_r instead of overflowing.
  assign term_hit_c = tick_c && (q_r == term_r);

`ifdef COUNT_CTRL_RELOAD_EN
  logic unused_ack;
  assign unused_ack = bus.ack;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      q_r    <= '0;
      psc_r  <= '0;
      term_r <= '0;
      pre_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_r    <= q_nxt;
      psc_r  <= psc_nxt;
      term_r <= term_nxt;
      pre_r  <= pre_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  // Next-state logic; stop outranks any tick in RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept_c) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
        end else if (term_hit_c) begin
`ifdef COUNT_CTRL_RELOAD_EN
          state_nxt = S_RUN;
`else
          state_nxt = S_DONE;
`endif
        end
      end
      S_DONE: begin
`ifdef COUNT_CTRL_RELOAD_EN
        state_nxt = S_IDLE;
`else
        if (bus.ack) state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered datapath and outputs.
  always_comb begin
    q_nxt    = q_r;
    psc_nxt  = psc_r;
    term_nxt = term_r;
    pre_nxt  = pre_r;
    wrap_nxt = 1'b0;
    busy_nxt = (state_nxt == S_RUN);
`ifdef COUNT_CTRL_RELOAD_EN
    done_nxt = 1'b0;
`else
    done_nxt = (state_nxt == S_DONE);
`endif
    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          term_nxt = bus.term;
          pre_nxt  = bus.prescale;
          q_nxt    = '0;
          psc_nxt  = '0;
        end
      end
      S_RUN: begin
        if (!bus.stop) begin
          psc_nxt = tick_c ? '0 : psc_r + PRESCALE_W'(1);
          if (term_hit_c) begin
            wrap_nxt = 1'b1;
`ifdef COUNT_CTRL_RELOAD_EN
            q_nxt    = '0;
`endif
          end else if (tick_c) begin
            q_nxt = q_r + WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.wrap = wrap_r;

endmodule
